// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request, alu and response signals of the shared-alu arbiter
interface alu_share_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_opcode;
    logic [1:0]  req0_funct;
    logic [15:0] req0_rs;
    logic [15:0] req0_rt;
    logic [15:0] req0_pc;
    logic [7:0]  req0_imm;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_opcode;
    logic [1:0]  req1_funct;
    logic [15:0] req1_rs;
    logic [15:0] req1_rt;
    logic [15:0] req1_pc;
    logic [7:0]  req1_imm;
    logic [4:0]  alu_opcode;
    logic [1:0]  alu_funct;
    logic [15:0] alu_rs;
    logic [15:0] alu_rt;
    logic [15:0] alu_pc;
    logic [7:0]  alu_imm;
    logic [15:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_res;

    modport master (
        output req0_valid, req0_opcode, req0_funct, req0_rs, req0_rt, req0_pc, req0_imm,
        output req1_valid, req1_opcode, req1_funct, req1_rs, req1_rt, req1_pc, req1_imm,
        input  req0_ready, req1_ready,
        input  alu_opcode, alu_funct, alu_rs, alu_rt, alu_pc, alu_imm,
        output alu_res,
        input  rsp_valid, rsp_id, rsp_res,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_funct, req0_rs, req0_rt, req0_pc, req0_imm,
        input  req1_valid, req1_opcode, req1_funct, req1_rs, req1_rt, req1_pc, req1_imm,
        output req0_ready, req1_ready,
        output alu_opcode, alu_funct, alu_rs, alu_rt, alu_pc, alu_imm,
        input  alu_res,
        output rsp_valid, rsp_id, rsp_res,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one alu between two requesters; ALU_ARB_RR_EN selects round-robin over fixed priority
module alu_share_arb #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_arb_if.slave   bus,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state, state_nxt;
    logic        win;
    logic        accept;
    logic        id_q;
    logic [4:0]  opcode_q;
    logic [1:0]  funct_q;
    logic [15:0] rs_q;
    logic [15:0] rt_q;
    logic [15:0] pc_q;
    logic [7:0]  imm_q;
    logic [15:0] res_q;
`ifdef ALU_ARB_RR_EN
    logic last_grant;
    assign win = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    always_ff @(posedge clk)
        if (rst) last_grant <= 1'b1;
        else if (accept) last_grant <= win;
`else
    assign win = ~bus.req0_valid & bus.req1_valid;
`endif
    always_comb begin
        accept         = state == IDLE && (win ? bus.req1_valid : bus.req0_valid);
        state_nxt      = state == IDLE ? (accept ? EXEC : IDLE) :
                         state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
        bus.req0_ready = state == IDLE && !win;
        bus.req1_ready = state == IDLE && win;
        bus.rsp_valid  = state == RESP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            id_q       <= 1'b0;
            opcode_q   <= '0;
            funct_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            res_q      <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                id_q     <= win;
                opcode_q <= win ? bus.req1_opcode : bus.req0_opcode;
                funct_q  <= win ? bus.req1_funct : bus.req0_funct;
                rs_q     <= win ? bus.req1_rs : bus.req0_rs;
                rt_q     <= win ? bus.req1_rt : bus.req0_rt;
                pc_q     <= win ? bus.req1_pc : bus.req0_pc;
                imm_q    <= win ? bus.req1_imm : bus.req0_imm;
                // increment is zero once the counter is all-ones, so it saturates
                if (win) grant_cnt1 <= grant_cnt1 + {{(CNT_W-1){1'b0}}, ~&grant_cnt1};
                else     grant_cnt0 <= grant_cnt0 + {{(CNT_W-1){1'b0}}, ~&grant_cnt0};
            end
            if (state == EXEC) res_q <= bus.alu_res;
        end
    end
    assign bus.alu_opcode = opcode_q;
    assign bus.alu_funct  = funct_q;
    assign bus.alu_rs     = rs_q;
    assign bus.alu_rt     = rt_q;
    assign bus.alu_pc     = pc_q;
    assign bus.alu_imm    = imm_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_res    = res_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed checks of the shared-alu arbiter, plus a CNT_W=2 instance for counter saturation
module tb_alu_share_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gc0, gc1;
    logic [1:0] gs0, gs1;
    int         tests = 0;
    int         fails = 0;
    int         n0, n1, e0, e1, budget;
    logic [7:0] order;
    logic [15:0] want;

    always #5 clk = ~clk;

    alu_share_arb_if ifc();
    alu_share_arb_if ifc2();

    alu_share_arb #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(ifc), .grant_cnt0(gc0), .grant_cnt1(gc1));
    alu_share_arb #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2), .grant_cnt0(gs0), .grant_cnt1(gs1));

    // tiny alu: add and lbi are all the bench uses
    assign ifc.alu_res = ifc.alu_opcode == 5'b11011 ? ifc.alu_rs + ifc.alu_rt :
                         ifc.alu_opcode == 5'b11000 ? {{8{ifc.alu_imm[7]}}, ifc.alu_imm} : 16'h0;

    assign ifc2.req0_valid  = 1'b1;
    assign ifc2.req0_opcode = 5'b11011;
    assign ifc2.req0_funct  = 2'b00;
    assign ifc2.req0_rs     = 16'h0001;
    assign ifc2.req0_rt     = 16'h0001;
    assign ifc2.req0_pc     = 16'h0;
    assign ifc2.req0_imm    = 8'h0;
    assign ifc2.req1_valid  = 1'b0;
    assign ifc2.req1_opcode = 5'b0;
    assign ifc2.req1_funct  = 2'b0;
    assign ifc2.req1_rs     = 16'h0;
    assign ifc2.req1_rt     = 16'h0;
    assign ifc2.req1_pc     = 16'h0;
    assign ifc2.req1_imm    = 8'h0;
    assign ifc2.alu_res     = 16'h0;
    assign ifc2.rsp_ready   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0();
        ifc.req0_valid  = n0 < 4;
        ifc.req0_opcode = 5'b11011;
        ifc.req0_funct  = 2'b00;
        ifc.req0_rs     = 16'h0010 + 16'(n0);
        ifc.req0_rt     = 16'h0001;
    endtask

    task automatic set_p1();
        ifc.req1_valid  = n1 < 4;
        ifc.req1_opcode = 5'b11011;
        ifc.req1_funct  = 2'b00;
        ifc.req1_rs     = 16'h0100 + 16'(n1);
        ifc.req1_rt     = 16'h0002;
    endtask

    // advance a requester's payload whenever its request is taken at this edge
    task automatic tick_track();
        logic a0, a1;
        #1;
        a0 = ifc.req0_valid && ifc.req0_ready;
        a1 = ifc.req1_valid && ifc.req1_ready;
        tick();
        if (a0) begin n0++; set_p0(); end
        if (a1) begin n1++; set_p1(); end
    endtask

    initial begin
        ifc.req0_valid = 0; ifc.req0_opcode = 0; ifc.req0_funct = 0; ifc.req0_rs = 0;
        ifc.req0_rt = 0; ifc.req0_pc = 0; ifc.req0_imm = 0;
        ifc.req1_valid = 0; ifc.req1_opcode = 0; ifc.req1_funct = 0; ifc.req1_rs = 0;
        ifc.req1_rt = 0; ifc.req1_pc = 0; ifc.req1_imm = 0;
        ifc.rsp_ready = 1;
        tick();
        tick();
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_rsp_id", ifc.rsp_id, 0);
        chk("rst_rsp_res", ifc.rsp_res, 0);
        chk("rst_cnt0", gc0, 0);
        chk("rst_cnt1", gc1, 0);
        chk("rst_alu_opcode", ifc.alu_opcode, 0);
        chk("rst_alu_rs", ifc.alu_rs, 0);
        chk("rst_sat_cnt", gs0, 0);

        // add 3+4 from req0
        rst = 0;
        ifc.req0_valid = 1; ifc.req0_opcode = 5'b11011; ifc.req0_funct = 2'b00;
        ifc.req0_rs = 16'h0003; ifc.req0_rt = 16'h0004; ifc.req0_pc = 16'h1234;
        #1;
        chk("t1_ready0", ifc.req0_ready, 1);
        chk("t1_ready1", ifc.req1_ready, 0);
        tick();
        ifc.req0_valid = 0;
        chk("t1_exec_valid", ifc.rsp_valid, 0);
        chk("t1_cnt0", gc0, 1);
        chk("t1_alu_rs", ifc.alu_rs, 16'h0003);
        chk("t1_alu_pc", ifc.alu_pc, 16'h1234);
        chk("t1_exec_ready0", ifc.req0_ready, 0);
        chk("t1_sat_cnt1", gs0, 1);
        tick();
        chk("t1_rsp_valid", ifc.rsp_valid, 1);
        chk("t1_rsp_id", ifc.rsp_id, 0);
        chk("t1_rsp_res", ifc.rsp_res, 16'h0007);
        tick();
        chk("t1_idle_valid", ifc.rsp_valid, 0);

        // lbi 0x80 from req1 only
        ifc.req1_valid = 1; ifc.req1_opcode = 5'b11000; ifc.req1_funct = 2'b00; ifc.req1_imm = 8'h80;
        #1;
        chk("t2_ready1", ifc.req1_ready, 1);
        chk("t2_ready0", ifc.req0_ready, 0);
        tick();
        ifc.req1_valid = 0;
        chk("t2_exec_ready0", ifc.req0_ready, 0);
        chk("t2_cnt1", gc1, 1);
        chk("t2_sat_cnt2", gs0, 2);
        tick();
        chk("t2_rsp_valid", ifc.rsp_valid, 1);
        chk("t2_rsp_id", ifc.rsp_id, 1);
        chk("t2_rsp_res", ifc.rsp_res, 16'hFF80);
        chk("t2_resp_ready0", ifc.req0_ready, 0);
        tick();
        chk("t2_idle_valid", ifc.rsp_valid, 0);

        // both requesters, four ops each
`ifdef ALU_ARB_RR_EN
        order = 8'b1010_1010;
`else
        order = 8'b1111_0000;
`endif
        n0 = 0; n1 = 0; e0 = 0; e1 = 0;
        set_p0();
        set_p1();
        for (int j = 0; j < 8; j++) begin
            budget = 0;
            while (!ifc.rsp_valid && budget < 10) begin
                tick_track();
                budget++;
            end
            chk("t3_rsp_valid", ifc.rsp_valid, 1);
            chk("t3_rsp_id", ifc.rsp_id, order[j]);
            if (order[j]) begin want = 16'h0102 + 16'(e1); e1++; end
            else          begin want = 16'h0011 + 16'(e0); e0++; end
            chk("t3_rsp_res", ifc.rsp_res, want);
            tick_track();
        end
        chk("t3_cnt0", gc0, 5);
        chk("t3_cnt1", gc1, 5);
        chk("t6_sat_a", gs0, 3);
        tick(); tick(); tick();
        chk("t6_sat_b", gs0, 3);

        // hold the response with rsp_ready low
        ifc.rsp_ready = 0;
        ifc.req0_valid = 1; ifc.req0_opcode = 5'b11011; ifc.req0_rs = 16'h0005; ifc.req0_rt = 16'h0006;
        tick();
        ifc.req0_rs = 16'h0009;
        ifc.req1_valid = 1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", ifc.rsp_valid, 1);
            chk("t4_hold_res", ifc.rsp_res, 16'h000B);
            chk("t4_hold_ready0", ifc.req0_ready, 0);
            chk("t4_hold_ready1", ifc.req1_ready, 0);
            tick();
        end
        chk("t4_hold_cnt0", gc0, 6);
        ifc.rsp_ready = 1;
        tick();
        chk("t4_release_valid", ifc.rsp_valid, 0);
        chk("t4_release_idle", ifc.req0_ready | ifc.req1_ready, 1);

        // reset while an op is in EXEC
        tick();
        chk("t5_in_exec", ifc.req0_ready | ifc.req1_ready | ifc.rsp_valid, 0);
        rst = 1;
        ifc.req0_valid = 0;
        ifc.req1_valid = 0;
        tick();
        rst = 0;
        chk("t5_rsp_valid", ifc.rsp_valid, 0);
        chk("t5_cnt0", gc0, 0);
        chk("t5_cnt1", gc1, 0);
        chk("t5_rsp_res", ifc.rsp_res, 0);
        #1;
        chk("t5_idle", ifc.req0_ready | ifc.req1_ready, 1);
        tick();
        tick();
        chk("t5_no_rsp", ifc.rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
